// File: rtl/cpu_core_mc_if.sv
// Instruction-memory port of cpu_core_mc: request/address out, ready/data back.
interface cpu_core_mc_if #(
  parameter int unsigned AW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle reduced-RV32 core: FETCH/EXEC/WB sequencing, internal register
// file, halts after last_pc retires or on an illegal instruction.
module cpu_core_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   last_pc,
  cpu_core_mc_if.master   imem,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);

  localparam int unsigned RIDX = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [AW-1:0]     next_pc_q, next_pc_d;
  logic              wr_q, wr_d;
  logic              exec_ill_q, exec_ill_d;
  logic              retire_q, retire_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              rf_we;
  logic [RIDX-1:0]   rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  // Decode fields of the latched instruction
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd_idx, rs1_idx, rs2_idx;
  logic              rd_ok, rs1_ok, rs2_ok;
  logic [XLEN-1:0]   rs1_v, rs2_v;
  logic [XLEN-1:0]   imm_i, imm_u;
  logic signed [12:0] imm_b;
  logic [AW-1:0]     pc_seq;
  logic [XLEN-1:0]   alu_res_c;
  logic [AW-1:0]     npc_c;
  logic              wr_c;
  logic              ill_c;

  assign opcode  = instr_q[6:0];
  assign rd_idx  = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign funct7  = instr_q[31:25];

  assign rd_ok   = 32'(rd_idx)  < NREGS;
  assign rs1_ok  = 32'(rs1_idx) < NREGS;
  assign rs2_ok  = 32'(rs2_idx) < NREGS;

  assign imm_i   = XLEN'($signed(instr_q[31:20]));
  assign imm_u   = XLEN'($signed({instr_q[31:12], 12'b0}));
  assign imm_b   = $signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0});
  assign pc_seq  = pc_q + AW'(1);

  // Register-file read ports; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_v = '0;
    rs2_v = '0;
    if (rs1_idx != 5'd0 && rs1_ok) rs1_v = regs_q[rs1_idx[RIDX-1:0]];
    if (rs2_idx != 5'd0 && rs2_ok) rs2_v = regs_q[rs2_idx[RIDX-1:0]];
  end

  // Debug read port
  always_comb begin
    dbg_rdata = '0;
    if (dbg_raddr != 5'd0 && 32'(dbg_raddr) < NREGS) dbg_rdata = regs_q[dbg_raddr[RIDX-1:0]];
  end

  // Execute: ALU result, next pc, write enable and legality of instr_q
  always_comb begin
    alu_res_c = '0;
    npc_c     = pc_seq;
    wr_c      = 1'b0;
    ill_c     = 1'b0;
    unique case (opcode)
      OPC_OPIMM: begin
        wr_c = 1'b1;
        if (!(rd_ok && rs1_ok)) ill_c = 1'b1;
        case (funct3)
          3'b000:  alu_res_c = rs1_v + imm_i;
          3'b010:  alu_res_c = XLEN'($signed(rs1_v) < $signed(imm_i));
          3'b100:  alu_res_c = rs1_v ^ imm_i;
          3'b110:  alu_res_c = rs1_v | imm_i;
          3'b111:  alu_res_c = rs1_v & imm_i;
          default: ill_c = 1'b1;
        endcase
      end
      OPC_OP: begin
        wr_c = 1'b1;
        if (!(rd_ok && rs1_ok && rs2_ok)) ill_c = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_res_c = rs1_v + rs2_v;
            3'b010:  alu_res_c = XLEN'($signed(rs1_v) < $signed(rs2_v));
            3'b100:  alu_res_c = rs1_v ^ rs2_v;
            3'b110:  alu_res_c = rs1_v | rs2_v;
            3'b111:  alu_res_c = rs1_v & rs2_v;
            default: ill_c = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_res_c = rs1_v - rs2_v;
        end else begin
          ill_c = 1'b1;
        end
      end
      OPC_LUI: begin
        wr_c      = 1'b1;
        alu_res_c = imm_u;
        if (!rd_ok) ill_c = 1'b1;
      end
      OPC_BRANCH: begin
        if (!(rs1_ok && rs2_ok)) ill_c = 1'b1;
        case (funct3)
          3'b000:  if (rs1_v == rs2_v) npc_c = pc_q + AW'(imm_b >>> 2);
          3'b001:  if (rs1_v != rs2_v) npc_c = pc_q + AW'(imm_b >>> 2);
          default: ill_c = 1'b1;
        endcase
      end
      default: ill_c = 1'b1;
    endcase
  end

  // Next-state and commit logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    result_d   = result_q;
    next_pc_d  = next_pc_q;
    wr_d       = wr_q;
    exec_ill_d = exec_ill_q;
    retire_d   = 1'b0;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    rf_we      = 1'b0;
    rf_waddr   = rd_idx[RIDX-1:0];
    rf_wdata   = result_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d   = alu_res_c;
        next_pc_d  = npc_c;
        wr_d       = wr_c;
        exec_ill_d = ill_c;
        retire_d   = !ill_c;
        state_d    = S_WB;
      end
      S_WB: begin
        if (!exec_ill_q) begin
          rf_we = wr_q && (rd_idx != 5'd0);
          pc_d  = next_pc_q;
        end
        if (pc_q == last_pc || exec_ill_q) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = exec_ill_q;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, datapath and register-file flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      instr_q    <= '0;
      result_q   <= '0;
      next_pc_q  <= '0;
      wr_q       <= 1'b0;
      exec_ill_q <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      result_q   <= result_d;
      next_pc_q  <= next_pc_d;
      wr_q       <= wr_d;
      exec_ill_q <= exec_ill_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Fetch request is a decode of the state flop, forced low while in reset
  assign imem.imem_req  = (state_q == S_FETCH) && rst_n;
  assign imem.imem_addr = pc_q;
  assign retire         = retire_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle ADDI-only core.
- Fetches 32-bit RV32 instructions over a ready-handshaked instruction-memory port and executes a reduced integer subset through a FETCH/EXEC/WB state machine.
- Owns an internal register file of NREGS registers and halts on a programmed last PC or on an illegal instruction.
- Sits under the CPU top, between the instruction ROM (or a stalling memory model) and a debug/trace bench.

Parameters:
- XLEN, 32: datapath and register width. Immediates are sign-extended to XLEN.
- NREGS, 16: architectural register count, 16 or 32. x0 is hardwired to zero.
- AW, 8: instruction word-address width. PC is a word address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- last_pc  in  AW  word address of the final instruction; halt after it retires.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch word address.
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  XLEN  combinational read of the register at dbg_raddr. Returns 0 for x0 or any index >= NREGS.
- retire  out  1  one-cycle pulse per committed instruction.
- halted  out  1  sticky halt flag.
- illegal  out  1  sticky; set when the halt was caused by an illegal instruction.

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=0, all registers 0, instr latch 0. retire=0, halted=0, illegal=0, imem_req=0 during reset. Asserting reset mid-instruction aborts it; no partial write survives.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - req and addr are held stable until a cycle with imem_ready=1.
  - In that cycle, latch imem_rdata into instr and go to EXEC.
  - imem_ready while not in FETCH is ignored.
- EXEC:
  - imem_req=0.
  - Decode instr and read rs1/rs2.
  - Compute result into a result register, compute next_pc, and set the illegal_d flag.
  - Go to WB.
- WB:
  - If not illegal: write rd when the instruction writes and rd!=0, then pc<=next_pc and pulse retire=1.
  - If pc==last_pc, or illegal_d is set, go to HALT; otherwise go to FETCH.
  - An illegal instruction: no register write, no retire, pc unchanged, halted=1, illegal=1.
- HALT: absorbing until reset. imem_req=0, no writes.
- Minimum latency is 3 cycles per instruction plus one cycle per imem_ready-low stall cycle in FETCH.
- Supported instructions; anything else is illegal:
  - OP-IMM (0010011): ADDI 000, SLTI 010, XORI 100, ORI 110, ANDI 111. imm=instr[31:20] sign-extended.
  - OP (0110011), funct7 0000000: ADD 000, SLT 010, XOR 100, OR 110, AND 111. funct7 0100000 with funct3 000 is SUB.
  - LUI (0110111): rd = {instr[31:12], 12'b0} sign-extended to XLEN.
  - BRANCH (1100011): BEQ 000, BNE 001. imm13={instr[31],instr[7],instr[30:25],instr[11:8],1'b0}. If taken, next_pc=pc+(imm13>>>2) truncated to AW bits. No rd write.
- Arithmetic rules:
  - Arithmetic is modulo 2^XLEN.
  - SLT/SLTI compare signed and write 1 or 0.
  - Non-branch next_pc=pc+1, wrapping from 2^AW-1 to 0.
- Any rd, rs1 or rs2 index >= NREGS makes the instruction illegal.
- Writes to x0 are discarded. Reads of x0 return 0.
- The halt check uses the pc of the instruction just retired, so a taken branch at last_pc still halts.

Test Plan:
- Program ADDI x1,x0,5; ADDI x2,x1,-7; last_pc=1; imem_ready tied 1 -> retire pulses at cycles 3 and 6; dbg x1=5, x2=0xFFFFFFFE; halted=1, illegal=0.
- x1=3, x2=10; SUB x3,x1,x2; SLT x4,x3,x0; ADD x0,x1,x2 -> x3=0xFFFFFFF9, x4=1, x0 reads 0.
- Loop: ADDI x1,x0,4; ADDI x1,x1,-1; BNE x1,x0,-4; last_pc=2 -> halts after the first BNE at pc 2 with x1=3. Rerun with last_pc=3 and a trailing ADDI at pc 3 -> 4 BNE retires, x1=0, halt after pc 3.
- Hold imem_ready=0 for 3 cycles on the second fetch -> imem_addr stays 1 and imem_req stays high throughout; instruction completes 3 cycles later; results unchanged.
- Fetch 0xFFFFFFFF at pc 2 -> no retire for it, halted=1, illegal=1, pc stays 2, no further imem_req. Same for ADDI x20,... with NREGS=16.
- Drop rst_n during WB of ADDI x5,x0,9 -> x5=0, pc=0, outputs 0 immediately. After release, fetch restarts at address 0.
